i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: the 7-bit address this target answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on SCL and SDA (minimum 2).
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i2c_scl, input, 1: bus clock, sampled only (no clock stretching).
REQ-006 SHALL have port i2c_sda, inout, 1: bus data; driven only to 0, otherwise 'z'.
REQ-007 SHALL have port rx_data, output, 8: last byte received in a write transfer.
REQ-008 SHALL have port rx_valid, output, 1: one-clk pulse when rx_data is updated.
REQ-009 SHALL have port tx_data, input, 8: byte to send in a read transfer, sampled when tx_req pulses.
REQ-010 SHALL have port tx_req, output, 1: one-clk pulse requesting the next tx_data byte.
REQ-011 SHALL have port busy, output, 1: high from an addressed START until STOP, repeated START or NACK release.

Function
REQ-012 SHALL synchronize SCL and SDA through SYNC_STAGES flops and derive scl_rise/scl_fall/sda_rise/sda_fall from the synchronized values.
REQ-013 SHALL detect START as sda_fall while SCL is high, and STOP as sda_rise while SCL is high, in every state.
REQ-014 SHALL implement states IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_DATA, TX_DATA, WAIT_ACK.
REQ-015 SHALL go to ADDR with bit counter = 7 on START from any state, including repeated START.
REQ-016 SHALL go to IDLE and release SDA on STOP from any state.
REQ-017 SHALL, in ADDR, shift SDA MSB-first on each scl_rise (7 address bits then the R/W bit), and on the 8th scl_fall go to ACK_ADDR if the address equals SLAVE_ADDR, else to IDLE.
REQ-018 SHALL drive SDA low during ACK_ADDR from that scl_fall to the next scl_fall, then go to RX_DATA (R/W=0) or TX_DATA (R/W=1).
REQ-019 SHALL, in RX_DATA, shift 8 bits MSB-first on scl_rise, and on the 8th scl_fall load rx_data, pulse rx_valid, and go to ACK_DATA.
REQ-020 SHALL drive SDA low for one SCL period in ACK_DATA (every byte ACKed), then return to RX_DATA.
REQ-021 SHALL pulse tx_req on entry to TX_DATA, capture tx_data one clk later, and drive SDA = 0 for each 0 bit (release for 1) MSB-first, changing only on scl_fall.
REQ-022 SHALL, after the 8th TX bit, release SDA and sample the master ACK on scl_rise in WAIT_ACK: ACK (0) goes back to TX_DATA, NACK (1) goes to IDLE.
REQ-023 SHALL ignore all bus activity in IDLE except START.
REQ-024 SHALL have SDA changes made by this block occur only while SCL is low.

Reset
REQ-025 SHALL, while reset is high at a clk edge, set state IDLE, release SDA, and set rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, counters=0; synchronizers preset to 1.
REQ-026 SHALL treat reset mid-transfer as an abort: the remainder of the transaction is ignored until the next START.

Configuration
REQ-027 SHALL, with I2C_SLAVE_READ_EN defined, support read transfers as in REQ-021/022.
REQ-028 SHALL, without I2C_SLAVE_READ_EN, NACK any address phase with R/W=1 (no ACK_ADDR, go to IDLE), never assert tx_req, and tie tx_data off.

Structure
REQ-029 SHALL define the state enum, SLAVE_ADDR_W=7 and BYTE_W=8 in shared package i2c_pkg, also used by i2c_master.
REQ-030 SHALL place synchronizer plus edge detect in sub-module i2c_sync_edge (one instance per bus line).

Verification
REQ-031 SHALL cover a write to 0x50 of byte 0xA5 -> address ACK, rx_data=0xA5 with one rx_valid pulse, data ACK, busy low after STOP.
REQ-032 SHALL cover a write to 0x51 -> SDA never driven low, no rx_valid, busy stays 0.
REQ-033 SHALL cover a read from 0x50 with tx_data=0x3C then 0xC3, master ACK then NACK -> bus bits 00111100 then 11000011, two tx_req pulses, then IDLE.
REQ-034 SHALL cover a write of 0x11 followed by repeated START and a write of 0x22 -> two rx_valid pulses with 0x11 then 0x22.
REQ-035 SHALL cover reset asserted after 4 address bits -> SDA released, state IDLE, next full write of 0x7E received correctly.
REQ-036 SHALL cover a read from 0x50 built without I2C_SLAVE_READ_EN -> address NACKed, tx_req never asserted.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg -- definitions shared by the I2C target (i2c_slave) and i2c_master.
//   i2c_state_t  : protocol FSM states
//   SLAVE_ADDR_W : width of a 7-bit bus address
//   BYTE_W       : width of one bus data byte
//   addr_match() : compares the address field of a received address frame
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int SLAVE_ADDR_W = 7;
  localparam int BYTE_W       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ACK_ADDR  = 3'd2,
    RX_DATA   = 3'd3,
    ACK_DATA  = 3'd4,
    TX_DATA   = 3'd5,
    WAIT_ACK  = 3'd6
  } i2c_state_t;

  // The address frame carries the address in its upper 7 bits, R/W in bit 0.
  function automatic logic addr_match(input logic [BYTE_W-1:0]       frame,
                                      input logic [SLAVE_ADDR_W-1:0] addr);
    return (frame[BYTE_W-1:1] == addr);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge -- brings one asynchronous bus line into the clk domain and
// flags its edges.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (chain preset to 1 = idle bus)
//   line  : raw bus line
//   level : synchronized line value
//   rise  : one-clk pulse on a 0->1 transition of level
//   fall  : one-clk pulse on a 1->0 transition of level
// ---------------------------------------------------------------------------
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], line};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave -- oversampling I2C target (no clock stretching).
// Build option: define I2C_SLAVE_READ_EN to support read transfers; without
// it every read address phase is NACKed and tx_data is unused.
// Ports:
//   clk      : system clock, all logic on rising edge
//   reset    : synchronous active-high reset (aborts any transfer)
//   i2c_scl  : bus clock, sampled only
//   i2c_sda  : bus data, driven to 0 or released
//   rx_data  : last byte received in a write transfer
//   rx_valid : one-clk pulse when rx_data updates
//   tx_data  : byte to send, sampled the clk after tx_req
//   tx_req   : one-clk pulse asking for the next tx_data byte
//   busy     : high from an addressed START until STOP / repeated START / NACK
// ---------------------------------------------------------------------------
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [SLAVE_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                      SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_req,
  output logic              busy
);

`ifdef I2C_SLAVE_READ_EN
  localparam logic READ_EN = 1'b1;
  logic [BYTE_W-1:0] tx_byte_s;
  assign tx_byte_s = tx_data;
`else
  localparam logic READ_EN = 1'b0;
  logic [BYTE_W-1:0] tx_byte_s;
  logic              tx_data_unused_s;
  assign tx_byte_s        = 8'h00;
  assign tx_data_unused_s = ^tx_data;
`endif

  logic scl_s, scl_rise_s, scl_fall_s;
  logic sda_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .line(i2c_scl),
    .level(scl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .line(i2c_sda),
    .level(sda_s), .rise(sda_rise_s), .fall(sda_fall_s)
  );

  // Both lines see identical latency, so SCL level is aligned with SDA edges.
  assign start_s = sda_fall_s & scl_s;
  assign stop_s  = sda_rise_s & scl_s;

  i2c_state_t        state_r, state_n;
  logic [2:0]        cnt_r, cnt_n;
  logic              done_r, done_n;     // 8th bit of current byte clocked in/out
  logic [BYTE_W-1:0] shift_r, shift_n;
  logic [BYTE_W-1:0] tx_shift_r, tx_shift_n;
  logic              rw_r, rw_n;
  logic              ack_r, ack_n;       // master ACKed the last read byte
  logic              sda_oe_r, sda_oe_n;
  logic [BYTE_W-1:0] rx_data_r, rx_data_n;
  logic              rx_valid_r, rx_valid_n;
  logic              tx_req_r, tx_req_n;
  logic              busy_r, busy_n;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      done_r     <= 1'b0;
      shift_r    <= 8'h00;
      tx_shift_r <= 8'h00;
      rw_r       <= 1'b0;
      ack_r      <= 1'b0;
      sda_oe_r   <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      done_r     <= done_n;
      shift_r    <= shift_n;
      tx_shift_r <= tx_shift_n;
      rw_r       <= rw_n;
      ack_r      <= ack_n;
      sda_oe_r   <= sda_oe_n;
      rx_data_r  <= rx_data_n;
      rx_valid_r <= rx_valid_n;
      tx_req_r   <= tx_req_n;
      busy_r     <= busy_n;
    end
  end

  // Next-state and output logic; START/STOP override every state.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    done_n     = done_r;
    shift_n    = shift_r;
    tx_shift_n = tx_shift_r;
    rw_n       = rw_r;
    ack_n      = ack_r;
    sda_oe_n   = sda_oe_r;
    rx_data_n  = rx_data_r;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy_r;

    if (start_s) begin
      state_n  = ADDR;
      cnt_n    = 3'd7;
      done_n   = 1'b0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_s) begin
      state_n  = IDLE;
      cnt_n    = 3'd0;
      done_n   = 1'b0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
        ADDR, RX_DATA: begin
          if (scl_rise_s) begin
            shift_n = {shift_r[BYTE_W-2:0], sda_s};
            if (cnt_r == 3'd0) begin
              done_n = 1'b1;
            end else begin
              cnt_n = cnt_r - 3'd1;
            end
          end else if (scl_fall_s && done_r) begin
            done_n = 1'b0;
            if (state_r == ADDR) begin
              // Reads are refused at the address phase when not supported.
              if (addr_match(shift_r, SLAVE_ADDR) && (!shift_r[0] || READ_EN)) begin
                state_n  = ACK_ADDR;
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                rw_n     = shift_r[0];
              end else begin
                state_n = IDLE;
              end
            end else begin
              rx_data_n  = shift_r;
              rx_valid_n = 1'b1;
              state_n    = ACK_DATA;
              sda_oe_n   = 1'b1;
            end
          end else begin
            state_n = state_r;
          end
        end
        ACK_ADDR: begin
          if (scl_fall_s) begin
            sda_oe_n = 1'b0;
            cnt_n    = 3'd7;
            done_n   = 1'b0;
            if (rw_r && READ_EN) begin
              state_n  = TX_DATA;
              tx_req_n = 1'b1;
            end else begin
              state_n = RX_DATA;
            end
          end else begin
            state_n = state_r;
          end
        end
        ACK_DATA: begin
          if (scl_fall_s) begin
            sda_oe_n = 1'b0;
            cnt_n    = 3'd7;
            done_n   = 1'b0;
            state_n  = RX_DATA;
          end else begin
            state_n = state_r;
          end
        end
        TX_DATA: begin
          // TX_DATA is always entered on an SCL fall, so the first bit can go
          // out as soon as the byte is captured.
          if (tx_req_r) begin
            tx_shift_n = tx_byte_s;
            sda_oe_n   = ~tx_byte_s[BYTE_W-1];
          end else if (scl_rise_s) begin
            if (cnt_r == 3'd0) begin
              done_n = 1'b1;
            end else begin
              cnt_n = cnt_r - 3'd1;
            end
          end else if (scl_fall_s) begin
            if (done_r) begin
              done_n   = 1'b0;
              sda_oe_n = 1'b0;
              state_n  = WAIT_ACK;
            end else begin
              tx_shift_n = {tx_shift_r[BYTE_W-2:0], 1'b0};
              sda_oe_n   = ~tx_shift_r[BYTE_W-2];
            end
          end else begin
            state_n = state_r;
          end
        end
        WAIT_ACK: begin
          // Sample on the rise, act on the following fall so the next byte's
          // first bit is never put on the bus while SCL is high.
          if (scl_rise_s) begin
            ack_n  = ~sda_s;
            done_n = 1'b1;
          end else if (scl_fall_s && done_r) begin
            done_n = 1'b0;
            if (ack_r) begin
              state_n  = TX_DATA;
              cnt_n    = 3'd7;
              tx_req_n = READ_EN;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            state_n = state_r;
          end
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  assign i2c_sda  = sda_oe_r ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_req   = tx_req_r;
  assign busy     = busy_r;

endmodule
